sha_round_pipe: RTL and testbench

Parametrised, pipelined SHA-2 compression round. It computes one full round per accepted transaction: the Ch, Maj, Σ0 and Σ1 terms, T1, T2 and the rotated working state a..h. It supports both SHA-256 (WIDTH=32) and SHA-512 (WIDTH=64), with a selectable pipeline depth and valid/ready handshakes on both sides. It sits between the message-schedule/K-constant feeder and the round-iteration controller in the hashing core, and it supersedes the stand-alone Ch unit.

---
 rtl/sha_round_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_sha_round_pipe.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_round_pipe.sv
// One SHA-2 compression round (SHA-256 or SHA-512) behind a 1- or 2-stage
// valid/ready pipeline; the sideband tag rides alongside each round.
module sha_round_pipe #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 1,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*WIDTH-1:0]   in_state,
  input  logic [WIDTH-1:0]     in_k,
  input  logic [WIDTH-1:0]     in_w,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WIDTH-1:0]   out_state,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int SW = 8 * WIDTH;

  if ((WIDTH != 32) && (WIDTH != 64)) begin : g_bad_width
    $error("sha_round_pipe: WIDTH must be 32 or 64");
  end
  if ((PIPE != 1) && (PIPE != 2)) begin : g_bad_pipe
    $error("sha_round_pipe: PIPE must be 1 or 2");
  end

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
    rotr = (x >> n) | (x << (WIDTH - n));
  endfunction

  function automatic logic [WIDTH-1:0] big_sigma0(input logic [WIDTH-1:0] x);
    if (WIDTH == 32) begin
      big_sigma0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    end else begin
      big_sigma0 = rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
    end
  endfunction

  function automatic logic [WIDTH-1:0] big_sigma1(input logic [WIDTH-1:0] x);
    if (WIDTH == 32) begin
      big_sigma1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    end else begin
      big_sigma1 = rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
    end
  endfunction

  function automatic logic [WIDTH-1:0] ch_f(input logic [WIDTH-1:0] e,
                                            input logic [WIDTH-1:0] f,
                                            input logic [WIDTH-1:0] g);
    ch_f = (e & f) ^ (~e & g);
  endfunction

  function automatic logic [WIDTH-1:0] maj_f(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c);
    maj_f = (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Concatenation widths truncate the sums, discarding carries out of the word.
  function automatic logic [SW-1:0] rotate_state(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c,
                                                 input logic [WIDTH-1:0] d,
                                                 input logic [WIDTH-1:0] e,
                                                 input logic [WIDTH-1:0] f,
                                                 input logic [WIDTH-1:0] g,
                                                 input logic [WIDTH-1:0] t1,
                                                 input logic [WIDTH-1:0] t2);
    rotate_state = {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  logic [WIDTH-1:0] in_a_s, in_b_s, in_c_s, in_d_s;
  logic [WIDTH-1:0] in_e_s, in_f_s, in_g_s, in_h_s;

  assign in_a_s = in_state[7*WIDTH +: WIDTH];
  assign in_b_s = in_state[6*WIDTH +: WIDTH];
  assign in_c_s = in_state[5*WIDTH +: WIDTH];
  assign in_d_s = in_state[4*WIDTH +: WIDTH];
  assign in_e_s = in_state[3*WIDTH +: WIDTH];
  assign in_f_s = in_state[2*WIDTH +: WIDTH];
  assign in_g_s = in_state[1*WIDTH +: WIDTH];
  assign in_h_s = in_state[0*WIDTH +: WIDTH];

  // Result presented to the output register by whichever front end is built.
  logic              res_valid_s;
  logic [SW-1:0]     res_state_s;
  logic [TAG_W-1:0]  res_tag_s;
  logic              out_room_s;
  logic              out_load_s;

  logic              out_v_q,     out_v_d;
  logic [SW-1:0]     out_state_q, out_state_d;
  logic [TAG_W-1:0]  out_tag_q,   out_tag_d;

  assign out_room_s = !out_v_q || out_ready;
  assign out_load_s = res_valid_s && out_room_s;

  if (PIPE == 1) begin : g_pipe1
    logic [WIDTH-1:0] t1_s, t2_s;

    assign t1_s = in_h_s + big_sigma1(in_e_s) + ch_f(in_e_s, in_f_s, in_g_s) + in_k + in_w;
    assign t2_s = big_sigma0(in_a_s) + maj_f(in_a_s, in_b_s, in_c_s);

    assign res_valid_s = in_valid;
    assign res_state_s = rotate_state(in_a_s, in_b_s, in_c_s, in_d_s,
                                      in_e_s, in_f_s, in_g_s, t1_s, t2_s);
    assign res_tag_s   = in_tag;
    assign in_ready    = out_room_s;
  end else begin : g_pipe2
    logic                 s1_v_q,    s1_v_d;
    logic [WIDTH-1:0]     s1_sig0_q, s1_sig0_d;
    logic [WIDTH-1:0]     s1_sig1_q, s1_sig1_d;
    logic [WIDTH-1:0]     s1_ch_q,   s1_ch_d;
    logic [WIDTH-1:0]     s1_maj_q,  s1_maj_d;
    logic [WIDTH-1:0]     s1_hkw_q,  s1_hkw_d;
    logic [7*WIDTH-1:0]   s1_ag_q,   s1_ag_d;
    logic [TAG_W-1:0]     s1_tag_q,  s1_tag_d;
    logic                 s1_room_s;
    logic                 s1_load_s;
    logic [WIDTH-1:0]     t1_s, t2_s;

    assign s1_room_s = !s1_v_q || out_room_s;
    assign s1_load_s = in_valid && s1_room_s;
    assign in_ready  = s1_room_s;

    // Stage-1 next state: capture the round terms, or empty out once forwarded.
    always_comb begin
      s1_v_d    = s1_v_q;
      s1_sig0_d = s1_sig0_q;
      s1_sig1_d = s1_sig1_q;
      s1_ch_d   = s1_ch_q;
      s1_maj_d  = s1_maj_q;
      s1_hkw_d  = s1_hkw_q;
      s1_ag_d   = s1_ag_q;
      s1_tag_d  = s1_tag_q;
      if (s1_load_s) begin
        s1_v_d    = 1'b1;
        s1_sig0_d = big_sigma0(in_a_s);
        s1_sig1_d = big_sigma1(in_e_s);
        s1_ch_d   = ch_f(in_e_s, in_f_s, in_g_s);
        s1_maj_d  = maj_f(in_a_s, in_b_s, in_c_s);
        s1_hkw_d  = in_h_s + in_k + in_w;
        s1_ag_d   = in_state[SW-1:WIDTH];
        s1_tag_d  = in_tag;
      end else if (out_room_s) begin
        s1_v_d    = 1'b0;
      end else begin
        s1_v_d    = s1_v_q;
      end
    end

    // Stage-1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_v_q    <= 1'b0;
        s1_sig0_q <= '0;
        s1_sig1_q <= '0;
        s1_ch_q   <= '0;
        s1_maj_q  <= '0;
        s1_hkw_q  <= '0;
        s1_ag_q   <= '0;
        s1_tag_q  <= '0;
      end else begin
        s1_v_q    <= s1_v_d;
        s1_sig0_q <= s1_sig0_d;
        s1_sig1_q <= s1_sig1_d;
        s1_ch_q   <= s1_ch_d;
        s1_maj_q  <= s1_maj_d;
        s1_hkw_q  <= s1_hkw_d;
        s1_ag_q   <= s1_ag_d;
        s1_tag_q  <= s1_tag_d;
      end
    end

    assign t1_s = s1_hkw_q + s1_sig1_q + s1_ch_q;
    assign t2_s = s1_sig0_q + s1_maj_q;

    assign res_valid_s = s1_v_q;
    assign res_state_s = rotate_state(s1_ag_q[6*WIDTH +: WIDTH], s1_ag_q[5*WIDTH +: WIDTH],
                                      s1_ag_q[4*WIDTH +: WIDTH], s1_ag_q[3*WIDTH +: WIDTH],
                                      s1_ag_q[2*WIDTH +: WIDTH], s1_ag_q[1*WIDTH +: WIDTH],
                                      s1_ag_q[0*WIDTH +: WIDTH], t1_s, t2_s);
    assign res_tag_s   = s1_tag_q;
  end

  // Output stage next state: payload holds steady while stalled.
  always_comb begin
    out_v_d     = out_v_q;
    out_state_d = out_state_q;
    out_tag_d   = out_tag_q;
    if (out_load_s) begin
      out_v_d     = 1'b1;
      out_state_d = res_state_s;
      out_tag_d   = res_tag_s;
    end else if (out_ready) begin
      out_v_d     = 1'b0;
    end else begin
      out_v_d     = out_v_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q     <= 1'b0;
      out_state_q <= '0;
      out_tag_q   <= '0;
    end else begin
      out_v_q     <= out_v_d;
      out_state_q <= out_state_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_v_q;
  assign out_state = out_state_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_sha_round_pipe.sv
// Scoreboard bench for sha_round_pipe: four configurations (W32/W64 x PIPE1/PIPE2)
// share one stimulus bus; sel picks the instance under test.
module tb_sha_round_pipe;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [1:0]   sel;
  logic [511:0] st;
  logic [63:0]  k;
  logic [63:0]  w;
  logic [3:0]   in_tag;

  logic iv0, iv1, iv2, iv3;
  logic or0, or1, or2, or3;
  logic ir0, ir1, ir2, ir3;
  logic ov0, ov1, ov2, ov3;
  logic [255:0] os0, os1;
  logic [511:0] os2, os3;
  logic [3:0]   ot0, ot1, ot2, ot3;

  logic         ir_m, ov_m;
  logic [511:0] os_m;
  logic [3:0]   ot_m;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed { logic [3:0] tag; logic [511:0] st; } exp_t;
  exp_t q[$];

  assign iv0 = in_valid && (sel == 2'd0);
  assign iv1 = in_valid && (sel == 2'd1);
  assign iv2 = in_valid && (sel == 2'd2);
  assign iv3 = in_valid && (sel == 2'd3);
  assign or0 = (sel == 2'd0) ? out_ready : 1'b1;
  assign or1 = (sel == 2'd1) ? out_ready : 1'b1;
  assign or2 = (sel == 2'd2) ? out_ready : 1'b1;
  assign or3 = (sel == 2'd3) ? out_ready : 1'b1;

  sha_round_pipe #(.WIDTH(32), .PIPE(1), .TAG_W(4)) u_w32p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_state(st[255:0]),
    .in_k(k[31:0]), .in_w(w[31:0]), .in_tag(in_tag), .out_valid(ov0), .out_ready(or0),
    .out_state(os0), .out_tag(ot0));
  sha_round_pipe #(.WIDTH(32), .PIPE(2), .TAG_W(4)) u_w32p2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_state(st[255:0]),
    .in_k(k[31:0]), .in_w(w[31:0]), .in_tag(in_tag), .out_valid(ov1), .out_ready(or1),
    .out_state(os1), .out_tag(ot1));
  sha_round_pipe #(.WIDTH(64), .PIPE(1), .TAG_W(4)) u_w64p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_state(st),
    .in_k(k), .in_w(w), .in_tag(in_tag), .out_valid(ov2), .out_ready(or2),
    .out_state(os2), .out_tag(ot2));
  sha_round_pipe #(.WIDTH(64), .PIPE(2), .TAG_W(4)) u_w64p2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_state(st),
    .in_k(k), .in_w(w), .in_tag(in_tag), .out_valid(ov3), .out_ready(or3),
    .out_state(os3), .out_tag(ot3));

  always_comb begin
    case (sel)
      2'd0:    begin ir_m = ir0; ov_m = ov0; os_m = {256'h0, os0}; ot_m = ot0; end
      2'd1:    begin ir_m = ir1; ov_m = ov1; os_m = {256'h0, os1}; ot_m = ot1; end
      2'd2:    begin ir_m = ir2; ov_m = ov2; os_m = os2;           ot_m = ot2; end
      default: begin ir_m = ir3; ov_m = ov3; os_m = os3;           ot_m = ot3; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cur_w();
    return sel[1] ? 64 : 32;
  endfunction

  function automatic logic [63:0] rotr_m(input logic [63:0] x, input int n, input int wd);
    logic [31:0] x32;
    if (wd == 32) begin
      x32 = x[31:0];
      return {32'h0, (x32 >> n) | (x32 << (32 - n))};
    end
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference round straight from the SHA-2 definitions, on 64-bit words masked to wd.
  function automatic logic [511:0] ref_round(input int wd, input logic [511:0] s,
                                             input logic [63:0] kk, input logic [63:0] ww);
    logic [63:0] v[8];
    logic [63:0] nv[8];
    logic [63:0] msk, s0, s1, chv, mj, t1, t2;
    logic [511:0] r;
    msk = (wd == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
    for (int i = 0; i < 8; i++)
      v[i] = (wd == 32) ? {32'h0, s[255-32*i -: 32]} : s[511-64*i -: 64];
    if (wd == 32) begin
      s0 = rotr_m(v[0], 2, wd) ^ rotr_m(v[0], 13, wd) ^ rotr_m(v[0], 22, wd);
      s1 = rotr_m(v[4], 6, wd) ^ rotr_m(v[4], 11, wd) ^ rotr_m(v[4], 25, wd);
    end else begin
      s0 = rotr_m(v[0], 28, wd) ^ rotr_m(v[0], 34, wd) ^ rotr_m(v[0], 39, wd);
      s1 = rotr_m(v[4], 14, wd) ^ rotr_m(v[4], 18, wd) ^ rotr_m(v[4], 41, wd);
    end
    chv = ((v[4] & v[5]) ^ (~v[4] & v[6])) & msk;
    mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
    t1  = (v[7] + s1 + chv + (kk & msk) + (ww & msk)) & msk;
    t2  = (s0 + mj) & msk;
    nv[0] = (t1 + t2) & msk;
    nv[1] = v[0]; nv[2] = v[1]; nv[3] = v[2];
    nv[4] = (v[3] + t1) & msk;
    nv[5] = v[4]; nv[6] = v[5]; nv[7] = v[6];
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (wd == 32) r[255-32*i -: 32] = nv[i][31:0];
      else          r[511-64*i -: 64] = nv[i];
    end
    return r;
  endfunction

  task automatic rand_in();
    for (int i = 0; i < 16; i++) st[i*32 +: 32] = $urandom;
    k = {$urandom, $urandom};
    w = {$urandom, $urandom};
    in_tag = 4'($urandom);
  endtask

  // One clock: sample handshakes, push the model result on accept, land on next negedge.
  task automatic tick(output bit acc, output bit got, output bit ovs,
                      output logic [511:0] gs, output logic [3:0] gt);
    #1;
    acc = in_valid && ir_m;
    got = ov_m && out_ready;
    ovs = ov_m;
    gs  = os_m;
    gt  = ot_m;
    if (acc) q.push_back('{tag: in_tag, st: ref_round(cur_w(), st, k, w)});
    @(negedge clk);
  endtask

  task automatic run_one(input logic [511:0] s, input logic [63:0] kk, input logic [63:0] ww,
                         input logic [3:0] tg, output int lat, output logic [511:0] gs,
                         output logic [3:0] gt, output logic [511:0] ms);
    bit acc, got, ovs;
    logic [511:0] x;
    logic [3:0] xt;
    q.delete();
    out_ready = 1'b1; st = s; k = kk; w = ww; in_tag = tg; in_valid = 1'b1;
    tick(acc, got, ovs, x, xt);
    in_valid = 1'b0;
    lat = -1; gs = '0; gt = '0; ms = '0;
    if (acc) begin
      ms = q[0].st;
      for (int n = 1; n <= 6; n++) begin
        if (lat < 0) begin
          tick(acc, got, ovs, x, xt);
          if (got) begin lat = n; gs = x; gt = xt; end
        end
      end
    end
    q.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      vectors++;
      if (ov_m !== 1'b0 || os_m !== 512'h0 || ot_m !== 4'h0 || ir_m !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_state sel=%0d: valid=%b state=%h tag=%h ready=%b, want 0/0/0/1",
                 i, ov_m, os_m, ot_m, ir_m);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sel = 2'd0;
    #1;
    vectors++;
    if (ov_m !== 1'b0 || ir_m !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: valid=%b ready=%b, want 0/1", ov_m, ir_m);
    end
    @(negedge clk);
  endtask

  task automatic test_fips(input int s);
    int lat;
    logic [511:0] gs, ms, exp_s;
    logic [3:0] gt;
    exp_s = {256'h0, 256'h5d6aebcd6a09e667bb67ae853c6ef372fa2a4622510e527f9b05688c1f83d9ab};
    sel = 2'(s);
    run_one({256'h0, 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19},
            64'h428a2f98, 64'h61626380, 4'hA, lat, gs, gt, ms);
    vectors++;
    if (lat != s + 1) begin
      miscompares++;
      $display("FAIL fips_latency pipe=%0d: got %0d cycles, want %0d", s + 1, lat, s + 1);
    end
    vectors++;
    if (gs !== exp_s || gt !== 4'hA) begin
      miscompares++;
      $display("FAIL fips_state pipe=%0d: got %h tag %h, want %h tag a", s + 1, gs, gt, exp_s);
    end
    vectors++;
    if (ms !== exp_s) begin
      miscompares++;
      $display("FAIL fips_model: model %h, want %h", ms, exp_s);
    end
  endtask

  task automatic test_ch_sigma1();
    int lat;
    logic [511:0] gs, ms, exp_s;
    logic [3:0] gt;
    exp_s = {256'h0, 32'he72da5d2, 32'h0, 32'h0, 32'h0,
             32'he72da5d2, 32'h0000ffff, 32'h1c72a972, 32'he38d56f2};
    sel = 2'd0;
    run_one({256'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000ffff, 32'h1c72a972, 32'he38d56f2, 32'h0},
            64'h0, 64'h0, 4'h3, lat, gs, gt, ms);
    vectors++;
    if (gs !== exp_s || lat != 1) begin
      miscompares++;
      $display("FAIL ch_sigma1: got %h (latency %0d), want %h (latency 1)", gs, lat, exp_s);
    end
  endtask

  task automatic test_rot64();
    int lat;
    logic [511:0] gs, ms, exp_s;
    logic [3:0] gt;
    exp_s = {64'h0004400000800000, 64'h0, 64'h0, 64'h0,
             64'h0004400000800000, 64'h1, 64'h0, 64'h0};
    for (int s = 2; s < 4; s++) begin
      sel = 2'(s);
      run_one({64'h0, 64'h0, 64'h0, 64'h0, 64'h1, 64'h0, 64'h0, 64'h0},
              64'h0, 64'h0, 4'h5, lat, gs, gt, ms);
      vectors++;
      if (gs !== exp_s || lat != s - 1) begin
        miscompares++;
        $display("FAIL rot64 pipe=%0d: got %h (latency %0d), want %h", s - 1, gs, lat, exp_s);
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc, got, ovs, held;
    logic [511:0] gs, hs;
    logic [3:0] gt, ht;
    exp_t e;
    int nxt, outs, first_c, last_c;
    sel = 2'd1; q.delete();
    out_ready = 1'b0; rand_in(); nxt = 1; in_tag = 4'd1; in_valid = 1'b1;
    held = 1'b0; hs = '0; ht = '0;
    for (int c = 0; c < 4; c++) begin
      tick(acc, got, ovs, gs, gt);
      if (acc) begin nxt++; rand_in(); in_tag = 4'(nxt); end
      if (ovs && !held) begin held = 1'b1; hs = gs; ht = gt; end
      else if (ovs) begin
        vectors++;
        if (gs !== hs || gt !== ht) begin
          miscompares++;
          $display("FAIL bp_stable: got %h tag %h, want %h tag %h", gs, gt, hs, ht);
        end
      end
    end
    #1;
    vectors++;
    if (nxt - 1 != 2 || ir_m !== 1'b0 || !held) begin
      miscompares++;
      $display("FAIL bp_stall: accepts %0d ready %b out_valid_seen %b, want 2/0/1",
               nxt - 1, ir_m, held);
    end
    out_ready = 1'b1; outs = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30 && outs < 5; c++) begin
      tick(acc, got, ovs, gs, gt);
      if (acc) begin
        nxt++; rand_in(); in_tag = 4'(nxt);
        if (nxt > 5) in_valid = 1'b0;
      end
      if (got) begin
        vectors++;
        e = (q.size() != 0) ? q.pop_front() : '0;
        if (gt !== 4'(outs + 1) || gs !== e.st || gt !== e.tag) begin
          miscompares++;
          $display("FAIL bp_order: got tag %h state %h, want tag %h state %h",
                   gt, gs, 4'(outs + 1), e.st);
        end
        if (first_c < 0) first_c = c;
        last_c = c; outs++;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (outs != 5 || last_c - first_c != 4 || q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_throughput: outputs %0d span %0d left %0d, want 5/4/0",
               outs, last_c - first_c, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    bit acc, got, ovs, seen;
    logic [511:0] gs;
    logic [3:0] gt;
    int n_acc;
    sel = 2'd1; q.delete();
    out_ready = 1'b0; rand_in(); in_valid = 1'b1; n_acc = 0;
    for (int c = 0; c < 6 && n_acc < 2; c++) begin
      tick(acc, got, ovs, gs, gt);
      if (acc) begin n_acc++; rand_in(); end
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (n_acc != 2 || ov_m !== 1'b0 || os_m !== 512'h0 || ir_m !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid: accepts %0d valid %b state %h ready %b, want 2/0/0/1",
               n_acc, ov_m, os_m, ir_m);
    end
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(acc, got, ovs, gs, gt);
      if (ovs) seen = 1'b1;
    end
    #1;
    vectors++;
    if (seen || ir_m !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_after: output seen %b ready %b, want 0/1", seen, ir_m);
    end
  endtask

  task automatic test_soak();
    bit acc, got, ovs;
    logic [511:0] gs;
    logic [3:0] gt;
    exp_t e;
    int accepted;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); q.delete(); accepted = 0;
      for (int c = 0; c < 20000 && accepted < 2500; c++) begin
        rand_in();
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        tick(acc, got, ovs, gs, gt);
        if (acc) accepted++;
        if (got) begin
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL soak_extra sel=%0d: tag %h with empty scoreboard", s, gt);
          end else begin
            e = q.pop_front();
            if (gs !== e.st || gt !== e.tag) begin
              miscompares++;
              $display("FAIL soak_data sel=%0d: got tag %h state %h, want tag %h state %h",
                       s, gt, gs, e.tag, e.st);
            end
          end
        end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
        tick(acc, got, ovs, gs, gt);
        if (got) begin
          vectors++;
          e = (q.size() != 0) ? q.pop_front() : '0;
          if (gs !== e.st || gt !== e.tag) begin
            miscompares++;
            $display("FAIL soak_drain_data sel=%0d: got tag %h state %h, want tag %h state %h",
                     s, gt, gs, e.tag, e.st);
          end
        end
      end
      vectors++;
      if (q.size() != 0 || accepted < 2500) begin
        miscompares++;
        $display("FAIL soak_count sel=%0d: accepted %0d left %0d, want 2500/0",
                 s, accepted, q.size());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 2'd0;
    st = '0; k = '0; w = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_fips(0);
    test_fips(1);
    test_ch_sigma1();
    test_rot64();
    test_backpressure();
    test_reset_midstream();
    test_soak();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
